controller: RTL and testbench
=============================

CONTROLLER -- requirements
Module: controller

Interface
REQ-001 Module SHALL have no parameters; width-independent; drives the 8-bit accumulator datapath's control strobes.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ena  input  1  phase-advance enable; 0 = hold current phase.
REQ-005 opcode  input  3  instruction register opcode: 000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 JMP.
REQ-006 zero  input  1  accumulator-is-zero flag from ALU.
REQ-007 sel  output  1  1 = memory address from PC, 0 = from IR operand field.
REQ-008 rd  output  1  memory read strobe.
REQ-009 ld_ir  output  1  load instruction register.
REQ-010 inc_pc  output  1  increment program counter.
REQ-011 halt  output  1  processor halted.
REQ-012 ld_pc  output  1  load PC from IR operand (jump).
REQ-013 data_e  output  1  enable accumulator onto data bus.
REQ-014 ld_ac  output  1  load accumulator from ALU result.
REQ-015 wr  output  1  memory write strobe.

Function
REQ-016 Internal 3-bit phase register SHALL increment by 1 on each rising clk edge with ena=1, wrapping 7->0; ena=0 holds it.
REQ-017 Phase names: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
REQ-018 All outputs SHALL be combinational decode of (phase, opcode, zero); no output latency beyond phase register; outputs not listed as 1 in a phase SHALL be 0.
REQ-019 ALUOP = opcode in {ADD, AND, XOR, LDA}.
REQ-020 Phase 0: sel=1.
REQ-021 Phase 1: sel=1, rd=1.
REQ-022 Phases 2 and 3: sel=1, rd=1, ld_ir=1.
REQ-023 Phase 4: inc_pc=1; halt=1 when opcode=HLT.
REQ-024 Phase 5: rd=ALUOP.
REQ-025 Phase 6: rd=ALUOP; inc_pc=1 when opcode=SKZ and zero=1; ld_pc=1 when opcode=JMP; data_e=1 when opcode=STO.
REQ-026 Phase 7: rd=ALUOP; ld_ac=ALUOP; ld_pc=1 when opcode=JMP; data_e and wr =1 when opcode=STO.
REQ-027 wr SHALL never be 1 while rd=1 (mutually exclusive by construction).
REQ-028 Opcode/zero changes mid-phase SHALL affect outputs immediately but never the phase sequence.

Reset
REQ-029 rst=1 SHALL force phase to 0 immediately, independent of clk and ena; outputs then sel=1, all others 0.
REQ-030 Reset deasserted mid-instruction SHALL restart at INST_ADDR; halted state (REQ-031) SHALL clear.

Configuration
REQ-031 Macro CTRL_HALT_LATCH_EN defined: HLT at phase 4 SHALL set a sticky halted flag on the clk edge with ena=1; while set, phase freezes at 4, halt=1, inc_pc=0, all other outputs 0; only rst clears it.
REQ-032 Macro CTRL_HALT_LATCH_EN undefined: halt is asserted only in phase 4 with opcode=HLT and phase keeps cycling; no halted flag exists.

Verification
REQ-033 rst pulse asynchronous mid-phase 5 -> phase 0 within same cycle, sel=1, others 0.
REQ-034 ena=1, opcode=ADD, 8 clocks -> phases 0..7 once; rd=1 in 1,2,3,5,6,7; ld_ir in 2,3; inc_pc in 4; ld_ac in 7 only; wraps to 0.
REQ-035 opcode=SKZ: zero=1 -> inc_pc=1 in phases 4 and 6; zero=0 -> inc_pc=1 in phase 4 only.
REQ-036 opcode=STO -> data_e=1 in phases 6,7; wr=1 in phase 7 only; rd=0 in 5..7; opcode=JMP -> ld_pc=1 in 6,7.
REQ-037 ena=0 for 3 clocks at phase 2 -> phase stays 2, ld_ir held 1; resumes to 3 when ena=1.
REQ-038 opcode=HLT: with CTRL_HALT_LATCH_EN, halt=1 from phase 4 onward for 10+ clocks until rst; without, halt=1 in phase 4 only and phase reaches 5.

Source files
------------

// File: rtl/controller.sv
// ----------------------------------------------------------------------------
// controller
//   Phase sequencer and control-strobe decoder for the 8-bit accumulator CPU.
//   An internal 3-bit phase counter walks through eight phases per
//   instruction; every strobe is a purely combinational decode of
//   (phase, opcode, zero).
//
//   Optional feature (macro CTRL_HALT_LATCH_EN):
//     defined   - HLT in OP_ADDR sets a sticky halted flag that freezes the
//                 phase at OP_ADDR and drives halt only, until rst.
//     undefined - halt is a plain decode in OP_ADDR; phase keeps cycling.
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   ena     in   phase-advance enable (0 holds the phase)
//   opcode  in   [2:0] instruction opcode
//   zero    in   accumulator-is-zero flag
//   sel     out  address mux: 1 = PC, 0 = IR operand
//   rd      out  memory read strobe
//   ld_ir   out  load instruction register
//   inc_pc  out  increment PC
//   halt    out  processor halted
//   ld_pc   out  load PC from IR operand
//   data_e  out  drive accumulator onto data bus
//   ld_ac   out  load accumulator
//   wr      out  memory write strobe
// ----------------------------------------------------------------------------
module controller (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       halt,
    output logic       ld_pc,
    output logic       data_e,
    output logic       ld_ac,
    output logic       wr
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    phase_t phase, phase_nxt;
    logic   alu_op;

    // Instructions that read an operand from memory and write the accumulator.
    assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);

`ifdef CTRL_HALT_LATCH_EN
    logic halted, halted_nxt;
    logic hlt_hit;

    // HLT seen in OP_ADDR on an enabled edge: latch halted, do not advance.
    assign hlt_hit = ena && (phase == OP_ADDR) && (opcode == OP_HLT);
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase  <= INST_ADDR;
`ifdef CTRL_HALT_LATCH_EN
            halted <= 1'b0;
`endif
        end else begin
            phase  <= phase_nxt;
`ifdef CTRL_HALT_LATCH_EN
            halted <= halted_nxt;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        phase_nxt = phase;
`ifdef CTRL_HALT_LATCH_EN
        halted_nxt = halted || hlt_hit;
        if (!halted && !hlt_hit && ena)
            phase_nxt = phase_t'(phase + 3'd1);
`else
        if (ena)
            phase_nxt = phase_t'(phase + 3'd1);
`endif
    end

    // Output decode
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        halt   = 1'b0;
        ld_pc  = 1'b0;
        data_e = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
`ifdef CTRL_HALT_LATCH_EN
        // A latched halt overrides the whole phase decode.
        if (halted)
            halt = 1'b1;
        else
`endif
        case (phase)
            INST_ADDR: begin
                sel = 1'b1;
            end
            INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            OP_ADDR: begin
                inc_pc = 1'b1;
                halt   = (opcode == OP_HLT);
            end
            OP_FETCH: begin
                rd = alu_op;
            end
            ALU_OP: begin
                rd     = alu_op;
                inc_pc = (opcode == OP_SKZ) && zero;
                ld_pc  = (opcode == OP_JMP);
                data_e = (opcode == OP_STO);
            end
            STORE: begin
                // rd only for ALU ops, wr only for STO: never both.
                rd     = alu_op;
                ld_ac  = alu_op;
                ld_pc  = (opcode == OP_JMP);
                data_e = (opcode == OP_STO);
                wr     = (opcode == OP_STO);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_controller.sv
// ----------------------------------------------------------------------------
// tb_controller
//   Table-driven bench for controller. Each table row is one clock cycle:
//   the inputs held during that cycle and the expected output vector
//   {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr}. Expected vectors
//   go into a scoreboard queue when a row is driven and are popped and
//   compared on the following falling edge. Hand-written sequences cover
//   asynchronous reset mid-phase and the halt/restart corner cases.
//   Honours CTRL_HALT_LATCH_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [2:0] opcode;
    logic       zero;
    logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;

    controller dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .halt   (halt),
        .ld_pc  (ld_pc),
        .data_e (data_e),
        .ld_ac  (ld_ac),
        .wr     (wr)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010,
                           AND_ = 3'b011, XOR_ = 3'b100, LDA = 3'b101,
                           STO = 3'b110, JMP = 3'b111;

    // Output vector order: sel rd ld_ir inc_pc halt ld_pc data_e ld_ac wr
    localparam logic [8:0] O_NONE  = 9'b000000000;
    localparam logic [8:0] O_P0    = 9'b100000000;
    localparam logic [8:0] O_P1    = 9'b110000000;
    localparam logic [8:0] O_P23   = 9'b111000000;
    localparam logic [8:0] O_P4    = 9'b000100000;
    localparam logic [8:0] O_RD    = 9'b010000000;
    localparam logic [8:0] O_RDLD  = 9'b010000010;
    localparam logic [8:0] O_INC   = 9'b000100000;
    localparam logic [8:0] O_DE    = 9'b000000100;
    localparam logic [8:0] O_DEWR  = 9'b000000101;
    localparam logic [8:0] O_LDPC  = 9'b000001000;
    localparam logic [8:0] O_P4HLT = 9'b000110000;
    localparam logic [8:0] O_HALT  = 9'b000010000;

    typedef struct {
        logic       ena;
        logic [2:0] op;
        logic       zero;
        logic [8:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [8:0] sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    function automatic logic [8:0] outs();
        return {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};
    endfunction

    task automatic add(input logic e, input logic [2:0] op, input logic z,
                       input logic [8:0] exp);
        vec_t v;
        v.ena = e; v.op = op; v.zero = z; v.exp = exp;
        vecs.push_back(v);
    endtask

    // Phases 0..3 are opcode independent.
    task automatic add_fetch(input logic [2:0] op, input logic z);
        add(1'b1, op, z, O_P0);
        add(1'b1, op, z, O_P1);
        add(1'b1, op, z, O_P23);
        add(1'b1, op, z, O_P23);
    endtask

    task automatic compare(input string name);
        logic [8:0] exp;
        logic [8:0] got;
        got = outs();
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %b", name, got);
        end else begin
            exp = sb.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s: got %b required %b", name, got, exp);
            end
        end
    endtask

    task automatic expect_now(input string name, input logic [8:0] exp);
        sb.push_back(exp);
        compare(name);
    endtask

    initial begin
        rst    = 1'b1;
        ena    = 1'b0;
        opcode = ADD;
        zero   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        expect_now("reset_state", O_P0);
        rst = 1'b0;

        // Asynchronous reset in the middle of OP_FETCH
        ena = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        expect_now("pre_rst_phase5", O_RD);
        #1 rst = 1'b1;
        #1 expect_now("async_rst_phase5", O_P0);
        @(posedge clk);
        #1 expect_now("rst_holds_phase0", O_P0);
        ena = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // ---------------- vector table ----------------
        // ADD: full instruction
        add_fetch(ADD, 1'b0);
        add(1'b1, ADD, 1'b0, O_P4);
        add(1'b1, ADD, 1'b0, O_RD);
        add(1'b1, ADD, 1'b0, O_RD);
        add(1'b1, ADD, 1'b0, O_RDLD);
        // SKZ with zero=1
        add_fetch(SKZ, 1'b1);
        add(1'b1, SKZ, 1'b1, O_P4);
        add(1'b1, SKZ, 1'b1, O_NONE);
        add(1'b1, SKZ, 1'b1, O_INC);
        add(1'b1, SKZ, 1'b1, O_NONE);
        // SKZ with zero=0
        add_fetch(SKZ, 1'b0);
        add(1'b1, SKZ, 1'b0, O_P4);
        add(1'b1, SKZ, 1'b0, O_NONE);
        add(1'b1, SKZ, 1'b0, O_NONE);
        add(1'b1, SKZ, 1'b0, O_NONE);
        // STO
        add_fetch(STO, 1'b0);
        add(1'b1, STO, 1'b0, O_P4);
        add(1'b1, STO, 1'b0, O_NONE);
        add(1'b1, STO, 1'b0, O_DE);
        add(1'b1, STO, 1'b0, O_DEWR);
        // JMP, with ena held low for 3 cycles in INST_LOAD
        add(1'b1, JMP, 1'b0, O_P0);
        add(1'b1, JMP, 1'b0, O_P1);
        add(1'b0, JMP, 1'b0, O_P23);
        add(1'b0, JMP, 1'b0, O_P23);
        add(1'b0, JMP, 1'b0, O_P23);
        add(1'b1, JMP, 1'b0, O_P23);
        add(1'b1, JMP, 1'b0, O_P23);
        add(1'b1, JMP, 1'b0, O_P4);
        add(1'b1, JMP, 1'b0, O_NONE);
        // opcode swapped while parked in ALU_OP: outputs follow, phase does not
        add(1'b0, JMP, 1'b0, O_LDPC);
        add(1'b1, STO, 1'b0, O_DE);
        add(1'b1, JMP, 1'b0, O_LDPC);
        // XOR: ALU op, zero flag irrelevant
        add_fetch(XOR_, 1'b1);
        add(1'b1, XOR_, 1'b1, O_P4);
        add(1'b1, XOR_, 1'b1, O_RD);
        add(1'b1, AND_, 1'b1, O_RD);
        add(1'b1, LDA, 1'b1, O_RDLD);
        // HLT
        add_fetch(HLT, 1'b0);
        add(1'b1, HLT, 1'b0, O_P4HLT);
`ifdef CTRL_HALT_LATCH_EN
        for (int i = 0; i < 10; i++)
            add(1'b1, HLT, 1'b0, O_HALT);
        add(1'b1, JMP, 1'b1, O_HALT);
        add(1'b1, STO, 1'b0, O_HALT);
`else
        add(1'b1, HLT, 1'b0, O_NONE);
        add(1'b1, HLT, 1'b0, O_NONE);
        add(1'b1, HLT, 1'b0, O_NONE);
        add(1'b1, HLT, 1'b0, O_P0);
`endif

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            ena    = vecs[i].ena;
            opcode = vecs[i].op;
            zero   = vecs[i].zero;
            sb.push_back(vecs[i].exp);
            @(negedge clk);
            compare($sformatf("vec%0d", i));
        end

        // Reset mid-cycle clears any halt and restarts at INST_ADDR
        #2 rst = 1'b1;
        #1 expect_now("rst_after_hlt", O_P0);
        ena = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        ena    = 1'b1;
        opcode = ADD;
        @(posedge clk);
        #1 expect_now("restart_phase1", O_P1);
        @(posedge clk);
        #1 expect_now("restart_phase2", O_P23);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
